// File: rtl/imem_boot_tx_if.sv
// Boot-load transmitter bus: image writes and start/gpi in, target pin drive and status out.
// Latency: n/a (pure signal bundle, no logic).
// Backpressure: none; start is a single-cycle request, done a single-cycle pulse.
interface imem_boot_tx_if #(
    parameter int WORDS  = 8,
    parameter int HALF_W = 6
);
    localparam int AW = $clog2(WORDS);

    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [2*HALF_W-1:0] wr_data;
    logic                start;
    logic [3:0]          gpi;
    logic                tgt_rst;
    logic [HALF_W-1:0]   tgt_data;
    logic                busy;
    logic                done;

    // Host side: loads the image, requests programming, supplies gpi.
    modport master (
        output wr_en, wr_addr, wr_data, start, gpi,
        input  tgt_rst, tgt_data, busy, done
    );

    // Transmitter side.
    modport slave (
        input  wr_en, wr_addr, wr_data, start, gpi,
        output tgt_rst, tgt_data, busy, done
    );
endinterface

// File: rtl/imem_boot_tx.sv
// Holds an image of WORDS x 2*HALF_W words and streams it, one half-word per clock, into the target.
// Latency: done pulses RST_CYCLES + 2*WORDS clocks after the edge that samples start; gpi passthrough 1 clock.
// Backpressure: none; start and image writes are ignored while busy, start is never queued.
module imem_boot_tx #(
    parameter int WORDS      = 8,
    parameter int HALF_W     = 6,
    parameter int RST_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    imem_boot_tx_if.slave    bus
);
    localparam int AW   = $clog2(WORDS);
    localparam int H_W  = $clog2(2 * WORDS);
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESET  = 2'd1,
        STREAM = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t              state;
    logic [2*HALF_W-1:0] image [WORDS];
    logic [RC_W-1:0]     rst_cnt;
    logic [H_W-1:0]      half_idx;
    logic [H_W-1:0]      next_half;
    logic [HALF_W-1:0]   next_half_dat;
    logic [HALF_W-1:0]   gpi_dat;
    logic                img_wr_ok;

    // The image is only writable while no stream is reading it.
    assign img_wr_ok = (state == IDLE) || (state == RUN);
    assign next_half = half_idx + 1'b1;
    assign gpi_dat   = {bus.gpi, {(HALF_W-4){1'b0}}};

    // Select the half-word presented after the current one: even index = low half, odd = high half.
    always_comb begin
        next_half_dat = image[next_half[H_W-1:1]][HALF_W-1:0];
        if (next_half[0]) begin
            next_half_dat = image[next_half[H_W-1:1]][2*HALF_W-1:HALF_W];
        end
    end

    // Image buffer: cleared by reset, written from the host when idle or running.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                image[i] <= '0;
            end
        end else if (bus.wr_en && img_wr_ok) begin
            image[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Protocol sequencer: hold target in reset, stream halves, then release and pass gpi through.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rst_cnt      <= '0;
            half_idx     <= '0;
            bus.tgt_rst  <= 1'b1;
            bus.tgt_data <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.tgt_rst  <= 1'b1;
                    bus.tgt_data <= '0;
                    if (bus.start) begin
                        state    <= RESET;
                        rst_cnt  <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                RESET: begin
                    // Release the target on the same edge that the first half-word appears.
                    if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                        bus.tgt_rst  <= 1'b0;
                        bus.tgt_data <= image[AW'(0)][HALF_W-1:0];
                        half_idx     <= '0;
                        state        <= STREAM;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    if (half_idx == H_W'(2 * WORDS - 1)) begin
                        bus.done     <= 1'b1;
                        bus.busy     <= 1'b0;
                        bus.tgt_data <= gpi_dat;
                        state        <= RUN;
                    end else begin
                        half_idx     <= next_half;
                        bus.tgt_data <= next_half_dat;
                    end
                end
                RUN: begin
                    bus.tgt_rst  <= 1'b0;
                    bus.tgt_data <= gpi_dat;
                    if (bus.start) begin
                        state        <= RESET;
                        rst_cnt      <= '0;
                        bus.busy     <= 1'b1;
                        bus.tgt_rst  <= 1'b1;
                        bus.tgt_data <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_boot_tx.sv
// Bench for imem_boot_tx: randomized images streamed into a target loader model and compared to an image model.
// Latency: observations taken 1 time unit after each rising edge.
// Backpressure: none modelled; start/wr_en injected mid-stream must be ignored.
module tb_imem_boot_tx;
    localparam int WORDS      = 8;
    localparam int HALF_W     = 6;
    localparam int RST_CYCLES = 2;
    localparam int NH         = 2 * WORDS;
    localparam int T_DONE     = RST_CYCLES + NH;
    localparam int NOBS       = T_DONE + 2;

    logic clk = 1'b0;
    logic rst;

    imem_boot_tx_if #(.WORDS(WORDS), .HALF_W(HALF_W)) bus ();

    imem_boot_tx #(.WORDS(WORDS), .HALF_W(HALF_W), .RST_CYCLES(RST_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference image as the host believes it to be.
    logic [11:0] img [WORDS];

    // Per-cycle observations of one programming sequence.
    logic       o_rst  [NOBS];
    logic [5:0] o_dat  [NOBS];
    logic       o_busy [NOBS];
    logic       o_done [NOBS];

    // Target-side loader: low half captured on even beats, word committed on odd beats.
    logic [11:0] ld_mem [WORDS];
    logic [5:0]  ld_lo;
    int          ld_h;

    always @(posedge clk) begin
        if (bus.tgt_rst) begin
            ld_h <= 0;
        end else if (ld_h < NH) begin
            if (ld_h % 2 == 0) ld_lo <= bus.tgt_data;
            else               ld_mem[ld_h / 2] <= {bus.tgt_data, ld_lo};
            ld_h <= ld_h + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [5:0] exp_half(input int h);
        logic [11:0] w;
        w = img[h / 2];
        return (h % 2 == 1) ? w[11:6] : w[5:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int a, input logic [11:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(a);
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
        img[a]    = d;
    endtask

    // Caller sets start (and optional write) before calling; the first tick samples it.
    task automatic capture(input int inj_t, input int rst_t, input logic [2:0] ia, input logic [11:0] id);
        tick();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        for (int t = 0; t < NOBS; t++) begin
            o_rst[t]  = bus.tgt_rst;
            o_dat[t]  = bus.tgt_data;
            o_busy[t] = bus.busy;
            o_done[t] = bus.done;
            if (t == inj_t) begin
                bus.start   = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_addr = ia;
                bus.wr_data = id;
            end
            if (t == rst_t) rst = 1'b1;
            tick();
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            rst       = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.tgt_rst !== 1'b1) begin n_fail++; $display("FAIL reset_tgt_rst got %b want 1", bus.tgt_rst); end
        n_cmp++; if (bus.tgt_data !== 6'h00) begin n_fail++; $display("FAIL reset_tgt_data got %h want 00", bus.tgt_data); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        rst = 1'b0;
        for (int i = 0; i < WORDS; i++) img[i] = '0;
        tick();
        n_cmp++; if (bus.tgt_rst !== 1'b1) begin n_fail++; $display("FAIL idle_tgt_rst got %b want 1", bus.tgt_rst); end
    endtask

    task automatic test_pattern_stream();
        for (int i = 0; i < WORDS; i++) write_word(i, 12'(12'h100 + i * 12'h011));
        bus.start = 1'b1;
        capture(-1, -1, 3'd0, 12'h000);
        for (int t = 0; t < NOBS; t++) begin
            n_cmp++; if (o_rst[t] !== (t < RST_CYCLES)) begin n_fail++; $display("FAIL pattern_rst t=%0d got %b want %b", t, o_rst[t], t < RST_CYCLES); end
            n_cmp++; if (o_busy[t] !== (t < T_DONE)) begin n_fail++; $display("FAIL pattern_busy t=%0d got %b want %b", t, o_busy[t], t < T_DONE); end
            n_cmp++; if (o_done[t] !== (t == T_DONE)) begin n_fail++; $display("FAIL pattern_done t=%0d got %b want %b", t, o_done[t], t == T_DONE); end
            if (t >= RST_CYCLES && t < T_DONE) begin
                n_cmp++; if (o_dat[t] !== exp_half(t - RST_CYCLES)) begin n_fail++; $display("FAIL pattern_data h=%0d got %h want %h", t - RST_CYCLES, o_dat[t], exp_half(t - RST_CYCLES)); end
            end
        end
        n_cmp++; if (o_dat[RST_CYCLES + 1] !== 6'h04) begin n_fail++; $display("FAIL pattern_word0_high got %h want 04", o_dat[RST_CYCLES + 1]); end
        for (int k = 0; k < WORDS; k++) begin
            n_cmp++; if (ld_mem[k] !== img[k]) begin n_fail++; $display("FAIL pattern_loaded w=%0d got %h want %h", k, ld_mem[k], img[k]); end
        end
    endtask

    task automatic test_gpi_run();
        logic [3:0] g;
        for (int i = 0; i < 9; i++) begin
            g = (i == 0) ? 4'hA : 4'($urandom);
            bus.gpi = g;
            tick();
            n_cmp++; if (bus.tgt_data !== {g, 2'b00}) begin n_fail++; $display("FAIL gpi_pass gpi=%h got %b want %b", g, bus.tgt_data, {g, 2'b00}); end
            n_cmp++; if (bus.tgt_rst !== 1'b0) begin n_fail++; $display("FAIL gpi_tgt_rst got %b want 0", bus.tgt_rst); end
        end
    endtask

    task automatic test_random_stream();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < WORDS; i++) write_word(i, 12'($urandom));
            bus.gpi   = 4'($urandom);
            bus.start = 1'b1;
            capture(-1, -1, 3'd0, 12'h000);
            for (int t = 0; t < NOBS; t++) begin
                n_cmp++; if (o_rst[t] !== (t < RST_CYCLES)) begin n_fail++; $display("FAIL random_rst r=%0d t=%0d got %b", r, t, o_rst[t]); end
                n_cmp++; if (o_done[t] !== (t == T_DONE)) begin n_fail++; $display("FAIL random_done r=%0d t=%0d got %b", r, t, o_done[t]); end
                if (t >= RST_CYCLES && t < T_DONE) begin
                    n_cmp++; if (o_dat[t] !== exp_half(t - RST_CYCLES)) begin n_fail++; $display("FAIL random_data r=%0d h=%0d got %h want %h", r, t - RST_CYCLES, o_dat[t], exp_half(t - RST_CYCLES)); end
                end
            end
            for (int k = 0; k < WORDS; k++) begin
                n_cmp++; if (ld_mem[k] !== img[k]) begin n_fail++; $display("FAIL random_loaded r=%0d w=%0d got %h want %h", r, k, ld_mem[k], img[k]); end
            end
        end
    endtask

    task automatic test_ignore_in_stream();
        logic [2:0] wa;
        wa = 3'($urandom);
        bus.start = 1'b1;
        // start + write at h=4, both must be dropped
        capture(RST_CYCLES + 4, -1, wa, ~img[wa]);
        for (int t = 0; t < NOBS; t++) begin
            n_cmp++; if (o_rst[t] !== (t < RST_CYCLES)) begin n_fail++; $display("FAIL ignore_rst t=%0d got %b", t, o_rst[t]); end
            n_cmp++; if (o_busy[t] !== (t < T_DONE)) begin n_fail++; $display("FAIL ignore_busy t=%0d got %b", t, o_busy[t]); end
            n_cmp++; if (o_done[t] !== (t == T_DONE)) begin n_fail++; $display("FAIL ignore_done t=%0d got %b", t, o_done[t]); end
            if (t >= RST_CYCLES && t < T_DONE) begin
                n_cmp++; if (o_dat[t] !== exp_half(t - RST_CYCLES)) begin n_fail++; $display("FAIL ignore_data h=%0d got %h want %h", t - RST_CYCLES, o_dat[t], exp_half(t - RST_CYCLES)); end
            end
        end
        // Re-program from RUN after a legal write; the dropped write must not appear.
        write_word((wa + 1) % WORDS, 12'($urandom));
        bus.start = 1'b1;
        capture(-1, -1, 3'd0, 12'h000);
        for (int t = 0; t < NOBS; t++) begin
            n_cmp++; if (o_rst[t] !== (t < RST_CYCLES)) begin n_fail++; $display("FAIL restart_rst t=%0d got %b", t, o_rst[t]); end
            if (t >= RST_CYCLES && t < T_DONE) begin
                n_cmp++; if (o_dat[t] !== exp_half(t - RST_CYCLES)) begin n_fail++; $display("FAIL restart_data h=%0d got %h want %h", t - RST_CYCLES, o_dat[t], exp_half(t - RST_CYCLES)); end
            end
        end
        n_cmp++; if (o_done[T_DONE] !== 1'b1) begin n_fail++; $display("FAIL restart_done got %b want 1", o_done[T_DONE]); end
    endtask

    task automatic test_mid_reset();
        int rt;
        rt = RST_CYCLES + 7;
        bus.start = 1'b1;
        capture(-1, rt, 3'd0, 12'h000);
        for (int t = 0; t < NOBS; t++) begin
            if (t <= rt) begin
                n_cmp++; if (o_busy[t] !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_pre t=%0d got %b want 1", t, o_busy[t]); end
                if (t >= RST_CYCLES) begin
                    n_cmp++; if (o_dat[t] !== exp_half(t - RST_CYCLES)) begin n_fail++; $display("FAIL midrst_data_pre h=%0d got %h want %h", t - RST_CYCLES, o_dat[t], exp_half(t - RST_CYCLES)); end
                end
            end else begin
                n_cmp++; if (o_rst[t] !== 1'b1) begin n_fail++; $display("FAIL midrst_tgt_rst t=%0d got %b want 1", t, o_rst[t]); end
                n_cmp++; if (o_dat[t] !== 6'h00) begin n_fail++; $display("FAIL midrst_data t=%0d got %h want 00", t, o_dat[t]); end
                n_cmp++; if (o_busy[t] !== 1'b0) begin n_fail++; $display("FAIL midrst_busy t=%0d got %b want 0", t, o_busy[t]); end
                n_cmp++; if (o_done[t] !== 1'b0) begin n_fail++; $display("FAIL midrst_done t=%0d got %b want 0", t, o_done[t]); end
            end
        end
        for (int i = 0; i < WORDS; i++) img[i] = '0;
        bus.start = 1'b1;
        capture(-1, -1, 3'd0, 12'h000);
        for (int t = RST_CYCLES; t < T_DONE; t++) begin
            n_cmp++; if (o_dat[t] !== exp_half(t - RST_CYCLES)) begin n_fail++; $display("FAIL midrst_cleared h=%0d got %h want %h", t - RST_CYCLES, o_dat[t], exp_half(t - RST_CYCLES)); end
        end
        n_cmp++; if (o_done[T_DONE] !== 1'b1) begin n_fail++; $display("FAIL midrst_rerun_done got %b want 1", o_done[T_DONE]); end
    endtask

    task automatic test_same_edge();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < WORDS; i++) img[i] = '0;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd0;
        bus.wr_data = 12'hFFF;
        bus.start   = 1'b1;
        img[0]      = 12'hFFF;
        capture(-1, -1, 3'd0, 12'h000);
        n_cmp++; if (o_dat[RST_CYCLES] !== 6'h3F) begin n_fail++; $display("FAIL same_edge_h0 got %h want 3f", o_dat[RST_CYCLES]); end
        n_cmp++; if (o_dat[RST_CYCLES + 1] !== 6'h3F) begin n_fail++; $display("FAIL same_edge_h1 got %h want 3f", o_dat[RST_CYCLES + 1]); end
        for (int t = RST_CYCLES + 2; t < T_DONE; t++) begin
            n_cmp++; if (o_dat[t] !== exp_half(t - RST_CYCLES)) begin n_fail++; $display("FAIL same_edge_rest h=%0d got %h want %h", t - RST_CYCLES, o_dat[t], exp_half(t - RST_CYCLES)); end
        end
        n_cmp++; if (o_done[T_DONE] !== 1'b1) begin n_fail++; $display("FAIL same_edge_done got %b want 1", o_done[T_DONE]); end
    endtask

    initial begin
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        bus.gpi     = '0;
        test_reset();
        test_pattern_stream();
        test_gpi_run();
        test_random_stream();
        test_ignore_in_stream();
        test_mid_reset();
        test_same_edge();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_boot_tx.md
Name: imem_boot_tx

Overview:
- Transmit end of the TinySoC boot-load protocol. Holds an 8-word × 12-bit program image and streams it to the SoC pin interface.
- Sequence: target reset pulse, then one 6-bit half-word per clock, low half first, 16 cycles total. After that it releases the target and passes general-purpose inputs through on the shared data pins.
- Lives in the board-side harness/FPGA wrapper that drives the SoC's rst and io_in[7:2], on the same clock.

Parameters:
- WORDS, 8, number of program words streamed; must match target instruction memory depth.
- HALF_W, 6, width of each transmitted half-word; word width is 2*HALF_W.
- RST_CYCLES, 2, number of consecutive clocks tgt_rst is held high before streaming (≥1).

Ports:
- clk  in  1  clock; also the target's clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  image buffer write strobe.
- wr_addr  in  $clog2(WORDS)  image buffer word address.
- wr_data  in  2*HALF_W  image word.
- start  in  1  single-cycle request to (re)program the target.
- gpi  in  4  value presented to the target's gpi pins once it runs.
- tgt_rst  out  1  drives target rst.
- tgt_data  out  HALF_W  drives target io_in[7:2].
- busy  out  1  high in RESET or STREAM.
- done  out  1  one-cycle pulse when the last half-word has been driven.

Behaviour:
- Reset (rst=1, sampled on posedge):
  - state=IDLE; all image words=0; tgt_rst=1; tgt_data=0; busy=0; done=0.
  - Takes effect mid-operation too: the stream aborts and the target is held in reset.
- All outputs are registered. Target samples them on the following posedge.
- Image writes:
  - When wr_en=1 in IDLE or RUN, the word at wr_addr is updated at the posedge.
  - Writes during RESET/STREAM are ignored.
- States:
  - IDLE: tgt_rst=1, tgt_data=0. start=1 → RESET, rst counter=0, busy=1.
  - RESET: tgt_rst=1 for exactly RST_CYCLES posedges, counted from entry.
    - On the final RESET cycle: tgt_rst←0, tgt_data←word[0][HALF_W-1:0], half index←0.
    - Then → STREAM.
  - STREAM: half index h runs 0..2*WORDS-1. Word k = h>>1.
    - Even h: tgt_data=word[k][HALF_W-1:0].
    - Odd h: tgt_data=word[k][2*HALF_W-1:HALF_W].
    - Advances one half per clock.
    - On the edge leaving h=2*WORDS-1: done←1 for one cycle, busy←0, → RUN.
  - RUN: tgt_rst=0; tgt_data={gpi, {HALF_W-4{1'b0}}}, registered, so 1-cycle latency. start=1 → RESET (re-program).
- start in RESET/STREAM is ignored; it is not queued.
- Stream timing:
  - tgt_data changes on the same edge that tgt_rst falls.
  - The target therefore captures the low half of word 0 on its first non-reset edge and commits word k on the edge after the high half is presented.
  - STREAM lasts exactly 2*WORDS cycles.
- Total latency from the start-sampling edge to the done pulse: RST_CYCLES + 2*WORDS clocks. Default: 18.
- Simultaneous wr_en and start in IDLE/RUN:
  - The write completes at that edge.
  - The stream uses the updated image.
- Counters saturate by state exit. No wrap inside STREAM.

Test Plan:
1. Reset, write word[i]=12'h100+i·0x11 for i=0..7, pulse start → tgt_rst high for exactly 2 clocks; then 16 tgt_data values 0x00,0x04,0x11,0x04,0x22,0x04… (low/high halves of 0x100,0x111,…); done pulses once at clock 18 after start; busy high for those 18 cycles.
2. Connect to the SoC loader model and stream a program (e.g. IMM r0←5; store to the gpo address; jump). → After done, the loaded imem equals the image and gpo shows 4'h5 within the expected cycles.
3. In RUN, drive gpi=4'hA → tgt_data=6'b101000 one clock later; tgt_rst stays 0.
4. Assert start and wr_en during STREAM → no restart, image unchanged, stream completes normally; then start in RUN → a fresh reset pulse and re-stream.
5. Assert rst mid-STREAM (h=7) → next edge tgt_rst=1, tgt_data=0, busy=0, no done pulse, image cleared to 0.
6. Same-edge wr_en(addr 0, 12'hFFF) and start in IDLE → first two streamed halves are 0x3F, 0x3F.
